// File: rtl/apb_uart_pkg.sv
// Shared constants for the APB UART receive front end: register map,
// ERROR/STATUS bit positions, legal DATA_SIZE range and the word mask helper.
package apb_uart_pkg;

    typedef enum logic [2:0] {
        ADDR_STATUS    = 3'd0,
        ADDR_ERROR     = 3'd1,
        ADDR_BP_LO     = 3'd2,
        ADDR_BP_HI     = 3'd3,
        ADDR_DATA_SIZE = 3'd4,
        ADDR_FIFO_CTRL = 3'd5,
        ADDR_RX_DATA   = 3'd6,
        ADDR_IRQ_EN    = 3'd7
    } apb_addr_e;

    localparam int unsigned ERR_FRAMING  = 0;
    localparam int unsigned ERR_OVERRUN  = 1;
    localparam int unsigned ERR_OVERFLOW = 2;

    localparam int unsigned STAT_NOT_EMPTY = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_THRESH    = 2;
    localparam int unsigned STAT_LEVEL_LSB = 3;

    localparam int unsigned DATA_SIZE_MIN = 5;
    localparam int unsigned DATA_SIZE_MAX = 8;

    // Keeps only the low 'size' bits of a received word.
    function automatic logic [7:0] mask_word(input logic [7:0] data, input logic [3:0] size);
        logic [7:0] m;
        for (int unsigned i = 0; i < 8; i++) begin
            m[i] = data[i] & (i < 32'(size));
        end
        return m;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO with push, pop, flush, head-of-queue output and fill level.
// DEPTH must be a power of two so the pointers wrap naturally.
module rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/apb_uart_rx_fifo.sv
// APB slave front end for the UART receiver: drains received words into a FIFO,
// holds sticky error flags, line configuration, FIFO threshold and interrupt.
module apb_uart_rx_fifo
    import apb_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH       = 8,
    parameter int unsigned BP_WIDTH         = 14,
    parameter int unsigned RESET_BIT_PERIOD = 10,
    parameter int unsigned RESET_DATA_SIZE  = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                psel,
    input  logic [2:0]          paddr,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [7:0]          pwdata,
    output logic [7:0]          prdata,
    output logic                pslverr,
    input  logic [7:0]          rx_data,
    input  logic                data_ready,
    input  logic                overrun_error,
    input  logic                framing_error,
    output logic                data_read,
    output logic [3:0]          data_size,
    output logic [BP_WIDTH-1:0] bit_period,
    output logic                irq
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    apb_addr_e         addr;
    logic              access, slverr, wr_ok;
    logic [BP_WIDTH-1:0] bp_q, bp_d;
    logic [3:0]        ds_q, ds_d;
    logic [4:0]        thr_q, thr_d;
    logic [1:0]        irq_en_q, irq_en_d;
    logic [2:0]        err_q, err_d;
    logic              data_read_q, data_read_d;
    logic              irq_q, irq_d;

    logic              push, pop, flush, push_req, overflow, err_clr;
    logic [7:0]        head, push_word;
    logic [LW-1:0]     level;
    logic              full, empty, thr_ge;
    logic [4:0]        thr_field;
    logic              flush_only, thr_bad;

    assign addr   = apb_addr_e'(paddr);
    assign access = psel & penable;

    // A write of only the flush bit (threshold field 0) flushes without touching
    // the threshold, so it is not treated as an illegal threshold write.
    assign thr_field  = pwdata[4:0];
    assign flush_only = pwdata[7] && (thr_field == '0);
    assign thr_bad    = !flush_only && ((thr_field == '0) || (thr_field > 5'(FIFO_DEPTH)));

    always_comb begin
        slverr = 1'b0;
        if (access) begin
            if (pwrite) begin
                case (addr)
                    ADDR_STATUS, ADDR_ERROR, ADDR_RX_DATA: slverr = 1'b1;
                    ADDR_DATA_SIZE: slverr = (pwdata < 8'(DATA_SIZE_MIN)) ||
                                             (pwdata > 8'(DATA_SIZE_MAX));
                    ADDR_FIFO_CTRL: slverr = thr_bad;
                    default:        slverr = 1'b0;
                endcase
            end else begin
                slverr = (addr == ADDR_RX_DATA) && empty;
            end
        end
    end

    assign wr_ok    = access & pwrite & ~slverr;
    assign pop      = access & ~pwrite & (addr == ADDR_RX_DATA) & ~empty;
    assign flush    = wr_ok & (addr == ADDR_FIFO_CTRL) & pwdata[7];
    assign err_clr  = access & ~pwrite & (addr == ADDR_ERROR);
    assign push_req = data_ready & ~data_read_q;
    assign push     = push_req & ~flush & (~full | pop);
    assign overflow = push_req & ~flush & full & ~pop;
    assign push_word = mask_word(rx_data, ds_q);
    assign thr_ge   = (5'(level) >= thr_q);

    rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk_i   (clk),
        .rst_ni  (n_rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (push_word),
        .head_o  (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        bp_d     = bp_q;
        ds_d     = ds_q;
        thr_d    = thr_q;
        irq_en_d = irq_en_q;
        if (wr_ok) begin
            case (addr)
                ADDR_BP_LO:     bp_d[7:0] = pwdata;
                ADDR_BP_HI:     bp_d[BP_WIDTH-1:8] = pwdata[BP_WIDTH-9:0];
                ADDR_DATA_SIZE: ds_d = pwdata[3:0];
                ADDR_FIFO_CTRL: if (thr_field != '0) thr_d = thr_field;
                ADDR_IRQ_EN:    irq_en_d = pwdata[1:0];
                default:        ;
            endcase
        end
    end

    // Same-cycle set beats clear-on-read.
    always_comb begin
        err_d = err_clr ? '0 : err_q;
        if (framing_error) err_d[ERR_FRAMING]  = 1'b1;
        if (overrun_error) err_d[ERR_OVERRUN]  = 1'b1;
        if (overflow)      err_d[ERR_OVERFLOW] = 1'b1;
    end

    assign data_read_d = push_req;
    assign irq_d       = (irq_en_q[0] & thr_ge) | (irq_en_q[1] & (|err_q));

    always_comb begin
        prdata = '0;
        if (access && !pwrite) begin
            case (addr)
                ADDR_STATUS:    prdata = {5'(level), thr_ge, full, ~empty};
                ADDR_ERROR:     prdata = {5'b0, err_q};
                ADDR_BP_LO:     prdata = bp_q[7:0];
                ADDR_BP_HI:     prdata = 8'(bp_q[BP_WIDTH-1:8]);
                ADDR_DATA_SIZE: prdata = {4'b0, ds_q};
                ADDR_FIFO_CTRL: prdata = {3'b0, thr_q};
                ADDR_RX_DATA:   prdata = empty ? 8'h00 : head;
                ADDR_IRQ_EN:    prdata = {6'b0, irq_en_q};
                default:        prdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bp_q        <= BP_WIDTH'(RESET_BIT_PERIOD);
            ds_q        <= 4'(RESET_DATA_SIZE);
            thr_q       <= 5'd1;
            irq_en_q    <= '0;
            err_q       <= '0;
            data_read_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            bp_q        <= bp_d;
            ds_q        <= ds_d;
            thr_q       <= thr_d;
            irq_en_q    <= irq_en_d;
            err_q       <= err_d;
            data_read_q <= data_read_d;
            irq_q       <= irq_d;
        end
    end

    assign pslverr    = slverr;
    assign data_read  = data_read_q;
    assign data_size  = ds_q;
    assign bit_period = bp_q;
    assign irq        = irq_q;

endmodule
